// File: rtl/ntt_pkg.sv
// Shared types and modular helpers for the q = 7681 NTT datapath.
package ntt_pkg;

  localparam int unsigned COEFF_W = 13;

  typedef logic [COEFF_W-1:0] coeff_t;

  localparam coeff_t MODULUS = 13'd7681;
  localparam coeff_t INV2    = 13'd3841;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // (a + b) mod q with a single conditional subtract; a, b < q
  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b, input coeff_t q);
    logic [COEFF_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    return COEFF_W'(sum);
  endfunction

  // (a - b) mod q, adding q back when the difference would go negative
  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b, input coeff_t q);
    logic [COEFF_W:0] diff;
    if (a < b) diff = {1'b0, a} + {1'b0, q} - {1'b0, b};
    else       diff = {1'b0, a} - {1'b0, b};
    return COEFF_W'(diff);
  endfunction

  // v * 2^-1 mod q: odd values borrow one q so the halving is exact
  function automatic coeff_t mod_half(input coeff_t v, input coeff_t q);
    logic [COEFF_W:0] t;
    t = {1'b0, v} + (v[0] ? {1'b0, q} : {(COEFF_W+1){1'b0}});
    return COEFF_W'(t >> 1);
  endfunction

endpackage

// File: rtl/intt_butterfly.sv
// Combinational inverse (Gentleman-Sande) butterfly: s = a+b, d = (a-b)*twiddle mod q.
module intt_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned MODULUS = 7681
) (
  input  coeff_t a,
  input  coeff_t b,
  input  coeff_t twiddle,
  output coeff_t s,
  output coeff_t d
);

  localparam int unsigned PROD_W = 2 * COEFF_W;
  localparam coeff_t      Q      = COEFF_W'(MODULUS);

  coeff_t              diff;
  logic [PROD_W-1:0]   prod;

  // Sum, difference and constant-modulus reduction of the twiddled difference
  always_comb begin
    s    = mod_add(a, b, Q);
    diff = mod_sub(a, b, Q);
    prod = PROD_W'(diff) * PROD_W'(twiddle);
    d    = COEFF_W'(prod % PROD_W'(MODULUS));
  end

endmodule

// File: rtl/intt_sdf_stage.sv
// One radix-2 SDF stage of the inverse NTT: delay FIFO, frame counter and
// IDLE/RUN/DRAIN control around a shared butterfly, with optional 2^-1 scaling.
module intt_sdf_stage
  import ntt_pkg::*;
#(
  parameter int unsigned             W             = 32,
  parameter int unsigned             MODULUS       = 7681,
  parameter int unsigned             FIFO_DEPTH    = 8,
  parameter logic [FIFO_DEPTH*W-1:0] TWIDDLE_ARRAY = {FIFO_DEPTH{W'(1)}},
  parameter bit                      SCALE_HALF    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] incoming_data,
  output logic         out_valid,
  output logic [W-1:0] final_result
);

  localparam int unsigned      CNT_W     = $clog2(2 * FIFO_DEPTH);
  localparam int unsigned      FIFO_BITS = FIFO_DEPTH * COEFF_W;
  localparam coeff_t           Q         = COEFF_W'(MODULUS);
  localparam logic [CNT_W-1:0] CNT_D     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * FIFO_DEPTH - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   pending, pending_nxt;
  logic [FIFO_BITS-1:0]   fifo;
  coeff_t                 res_q;

  logic                   accept, phase_b, advance, emit;
  coeff_t                 x, head, tw, push_val, emit_val, out_val;
  coeff_t                 bf_s, bf_d;

  assign x            = COEFF_W'(incoming_data);
  assign head         = fifo[FIFO_BITS-1 -: COEFF_W];
  assign accept       = in_valid && in_ready;
  assign phase_b      = (cnt >= CNT_D);
  assign final_result = W'(res_q);

  // Twiddle for the current phase-B position (index cnt - D)
  always_comb begin
    tw = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      if (cnt == CNT_W'(FIFO_DEPTH + k)) tw = COEFF_W'(TWIDDLE_ARRAY[k*W +: W]);
    end
  end

  intt_butterfly #(
    .MODULUS (MODULUS)
  ) u_bf (
    .a       (head),
    .b       (x),
    .twiddle (tw),
    .s       (bf_s),
    .d       (bf_d)
  );

  // Next-state, counter, FIFO advance and emission decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    advance     = 1'b0;
    push_val    = '0;
    emit        = 1'b0;
    emit_val    = '0;

    case (state)
      IDLE, RUN: begin
        if (accept) begin
          advance   = 1'b1;
          state_nxt = RUN;
          if (phase_b) begin
            push_val = bf_d;
            emit     = 1'b1;
            emit_val = bf_s;
            if (cnt == CNT_LAST) begin
              cnt_nxt     = '0;
              pending_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            push_val = x;
            emit     = pending;
            emit_val = head;
            cnt_nxt  = cnt + CNT_W'(1);
          end
        end else if (state == RUN && cnt == '0 && pending) begin
          // Bubble at a frame boundary: start flushing the stored differences
          advance  = 1'b1;
          emit     = 1'b1;
          emit_val = head;
          if (FIFO_DEPTH == 1) begin
            state_nxt   = IDLE;
            pending_nxt = 1'b0;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt == CNT_D) begin
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          advance  = 1'b1;
          emit     = 1'b1;
          emit_val = head;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    out_val = SCALE_HALF ? mod_half(emit_val, Q) : emit_val;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      in_ready  <= (state_nxt != DRAIN);
      out_valid <= emit;
      if (emit) res_q <= out_val;
    end
  end

  // Delay line: one push at the tail and one pop from the head per advance
  always_ff @(posedge clk) begin
    if (advance) fifo <= FIFO_BITS'({fifo, push_val});
  end

endmodule

// File: tb/tb_intt_sdf_stage.sv
// Directed bench for intt_sdf_stage across four parameterisations.
module tb_intt_sdf_stage;

  logic        clk;
  logic        rst;
  logic        iv   [4];
  logic [31:0] din  [4];
  logic        ir   [4];
  logic        ov   [4];
  logic [31:0] dout [4];

  int tests = 0;
  int fails = 0;

  int a5 [8] = '{50, 150, 250, 350, 450, 550, 650, 750};
  int b5 [8] = '{0, 10, 20, 30, 40, 50, 60, 7000};
  int s5 [8] = '{50, 160, 270, 380, 490, 600, 710, 69};
  int d5 [8] = '{50, 140, 230, 320, 410, 500, 590, 1431};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  intt_sdf_stage #(.W(32), .MODULUS(7681), .FIFO_DEPTH(2),
                   .TWIDDLE_ARRAY({32'd17, 32'd1}), .SCALE_HALF(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .incoming_data(din[0]), .out_valid(ov[0]), .final_result(dout[0]));

  intt_sdf_stage #(.W(32), .MODULUS(7681), .FIFO_DEPTH(2),
                   .TWIDDLE_ARRAY({32'd17, 32'd1}), .SCALE_HALF(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .incoming_data(din[1]), .out_valid(ov[1]), .final_result(dout[1]));

  intt_sdf_stage #(.W(32), .MODULUS(7681), .FIFO_DEPTH(1),
                   .TWIDDLE_ARRAY(32'd1), .SCALE_HALF(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .incoming_data(din[2]), .out_valid(ov[2]), .final_result(dout[2]));

  intt_sdf_stage #(.W(32), .MODULUS(7681), .FIFO_DEPTH(8),
                   .SCALE_HALF(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .incoming_data(din[3]), .out_valid(ov[3]), .final_result(dout[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle on instance i, then check its registered output
  task automatic step(input int i, input bit v, input int x, input bit ev, input int ex,
                      input string tag);
    iv[i]  = v;
    din[i] = 32'(x);
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
    chk({tag, " valid"}, 32'(ov[i]), 32'(ev));
    if (ev) chk({tag, " data"}, dout[i], 32'(ex));
  endtask

  initial begin
    int lows;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[i]  = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst ov%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst out%0d", i), dout[i], 32'd0);
      chk($sformatf("rst rdy%0d", i), 32'(ir[i]), 32'd1);
    end

    // 1: D=2, no scaling, back-to-back frames then a drain
    step(0, 1, 10, 0, 0,    "t1 x0");
    step(0, 1, 20, 0, 0,    "t1 x1");
    step(0, 1, 30, 1, 40,   "t1 s0");
    step(0, 1, 5,  1, 25,   "t1 s1");
    step(0, 1, 1,  1, 7661, "t1 d0");
    step(0, 1, 2,  1, 255,  "t1 d1");
    step(0, 1, 3,  1, 4,    "t1 s0b");
    step(0, 1, 4,  1, 6,    "t1 s1b");
    step(0, 0, 0,  1, 7679, "t1 d0b");
    chk("t1 rdy drain0", 32'(ir[0]), 32'd0);
    step(0, 0, 0,  1, 7647, "t1 d1b");
    chk("t1 rdy drain1", 32'(ir[0]), 32'd0);
    step(0, 0, 0,  0, 0,    "t1 idle");
    chk("t1 rdy idle", 32'(ir[0]), 32'd1);

    // 2: same frames with every output halved
    step(1, 1, 10, 0, 0,    "t2 x0");
    step(1, 1, 20, 0, 0,    "t2 x1");
    step(1, 1, 30, 1, 20,   "t2 s0");
    step(1, 1, 5,  1, 3853, "t2 s1");
    step(1, 1, 1,  1, 7671, "t2 d0");
    step(1, 1, 2,  1, 3968, "t2 d1");
    step(1, 1, 3,  1, 2,    "t2 s0b");
    step(1, 1, 4,  1, 3,    "t2 s1b");
    step(1, 0, 0,  1, 7680, "t2 d0b");
    step(1, 0, 0,  1, 7664, "t2 d1b");
    step(1, 0, 0,  0, 0,    "t2 idle");

    // 3: D=1, sum wraps to zero, drain goes straight back to IDLE
    step(2, 1, 7680, 0, 0,    "t3 x0");
    step(2, 1, 1,    1, 0,    "t3 s0");
    step(2, 0, 0,    1, 7679, "t3 d0");
    chk("t3 rdy", 32'(ir[2]), 32'd1);
    step(2, 0, 0,    0, 0,    "t3 idle");
    step(2, 1, 3,    0, 0,    "t3 x0b");
    step(2, 1, 5,    1, 8,    "t3 s0b");
    step(2, 0, 0,    1, 7679, "t3 d0b");
    step(2, 0, 0,    0, 0,    "t3 idle2");

    // 4: stall between samples 2 and 3 leaves results unchanged
    step(0, 1, 10, 0, 0, "t4 x0");
    step(0, 1, 20, 0, 0, "t4 x1");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, "t4 stall");
      chk("t4 rdy stall", 32'(ir[0]), 32'd1);
    end
    step(0, 1, 30, 1, 40,   "t4 s0");
    step(0, 1, 5,  1, 25,   "t4 s1");
    step(0, 0, 0,  1, 7661, "t4 d0");
    step(0, 0, 0,  1, 255,  "t4 d1");
    step(0, 0, 0,  0, 0,    "t4 idle");
    step(0, 0, 0,  0, 0,    "t4 idle2");

    // 5: D=8 single frame, full drain, then a clean second frame
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 8; k++) step(3, 1, a5[k], 0, 0, "t5 phaseA");
      for (int k = 0; k < 8; k++) step(3, 1, b5[k], 1, s5[k], $sformatf("t5 s%0d", k));
      lows = 0;
      for (int k = 0; k < 8; k++) begin
        step(3, 0, 0, 1, d5[k], $sformatf("t5 d%0d", k));
        if (!ir[3]) lows++;
      end
      step(3, 0, 0, 0, 0, "t5 drain end");
      if (!ir[3]) lows++;
      chk("t5 rdy low cycles", 32'(lows), 32'd8);
      step(3, 0, 0, 0, 0, "t5 idle");
    end

    // 6: async reset in phase B, then a fresh frame
    step(0, 1, 10, 0, 0,  "t6 x0");
    step(0, 1, 20, 0, 0,  "t6 x1");
    step(0, 1, 30, 1, 40, "t6 s0");
    #2;
    rst = 1'b0;
    #1;
    chk("t6 rst ov", 32'(ov[0]), 32'd0);
    chk("t6 rst out", dout[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 1, 10, 0, 0,    "t6 x0b");
    step(0, 1, 20, 0, 0,    "t6 x1b");
    step(0, 1, 30, 1, 40,   "t6 s0b");
    step(0, 1, 5,  1, 25,   "t6 s1b");
    step(0, 0, 0,  1, 7661, "t6 d0b");
    step(0, 0, 0,  1, 255,  "t6 d1b");
    step(0, 0, 0,  0, 0,    "t6 idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
